sha_256_stream: RTL and testbench

//   Streaming SHA-256 engine: accepts a message of arbitrary length as 32-bit big-endian words via valid/ready,

---
 rtl/sha256_pkg.sv | 68 ++++++
 rtl/sha256_round.sv | 25 ++
 rtl/sha_256_stream.sv | 227 ++++++++++++++++++++++
 tb/tb_sha_256_stream.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: round constants, initial hash value, FSM state type
// and the FIPS 180-4 logical functions used by the round and message schedule.
package sha256_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPad,
        StCompress,
        StFinal,
        StDone
    } sha_state_e;

    // Ascending packed range so K[0] is the first constant listed.
    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // H0 in [255:224] down to H7 in [31:0].
    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, y, z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, y, z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round.
//   i_state : working variables a..h, a in [255:224]
//   i_w     : schedule word for this round
//   i_k     : round constant
//   o_state : updated a..h
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] i_state,
    input  logic [31:0]  i_w,
    input  logic [31:0]  i_k,
    output logic [255:0] o_state
);

    logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    logic [31:0] w_t1, w_t2;

    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_state;

    assign w_t1 = w_h + bsig1(w_e) + ch(w_e, w_f, w_g) + i_k + i_w;
    assign w_t2 = bsig0(w_a) + maj(w_a, w_b, w_c);

    assign o_state = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule

// File: rtl/sha_256_stream.sv
// Streaming SHA-256: takes big-endian 32-bit words, pads in hardware, hashes any
// number of 512-bit blocks and presents the 256-bit digest.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_in_data/valid/last  : message word stream; o_in_ready accepts
//   i_in_bytes            : valid bytes (MSB-aligned) in the word, 0..4
//   o_digest/_valid       : H0..H7 (H0 in [255:224]); held until i_digest_ready
//   o_busy                : message in flight
module sha_256_stream
    import sha256_pkg::*;
#(
    parameter int unsigned UNROLL = 1,
    parameter int unsigned LEN_W  = 64
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [31:0]  i_in_data,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic         i_in_last,
    input  logic [2:0]   i_in_bytes,
    output logic [255:0] o_digest,
    output logic         o_digest_valid,
    input  logic         i_digest_ready,
    output logic         o_busy
);

    localparam logic [5:0] LastRound = 6'(64 - UNROLL);

    sha_state_e r_state, w_state_next;

    logic [31:0]      r_w [16];
    logic [3:0]       r_idx;
    logic [5:0]       r_round;
    logic [255:0]     r_h;
    logic [255:0]     r_work;
    logic [LEN_W-1:0] r_bitcnt;
    logic             r_rdy_en;     // holds in_ready low for the reset release cycle
    logic             r_msg_done;   // last word received
    logic             r_pend80;     // 0x80 marker still owed (last word was full)
    logic             r_len_ok;     // this block has room for the length words
    logic             r_final_blk;  // block being compressed carries the length

    logic              w_accept;
    logic [31:0]       w_in_word;
    logic [31:0]       w_pad_word;
    logic [63:0]       w_len;
    logic [255:0]      w_round_out;
    logic [UNROLL*32-1:0] w_wr_all;

    assign o_in_ready     = r_rdy_en && (r_state == StIdle || r_state == StLoad);
    assign o_digest_valid = (r_state == StDone);
    assign o_digest       = (r_state == StDone) ? r_h : '0;
    assign o_busy         = (r_state != StIdle);
    assign w_accept       = i_in_valid && o_in_ready;
    assign w_len          = 64'(r_bitcnt);

    // Last word: mask unused bytes and append the 0x80 marker right after them.
    always_comb begin
        w_in_word = i_in_data;
        if (i_in_last) begin
            case (i_in_bytes)
                3'd0:    w_in_word = 32'h8000_0000;
                3'd1:    w_in_word = {i_in_data[31:24], 24'h80_0000};
                3'd2:    w_in_word = {i_in_data[31:16], 16'h8000};
                3'd3:    w_in_word = {i_in_data[31:8], 8'h80};
                default: w_in_word = i_in_data;
            endcase
        end
    end

    always_comb begin
        w_pad_word = '0;
        if (r_pend80) begin
            w_pad_word = 32'h8000_0000;
        end else if (r_len_ok && r_idx == 4'd14) begin
            w_pad_word = w_len[63:32];
        end else if (r_len_ok && r_idx == 4'd15) begin
            w_pad_word = w_len[31:0];
        end
    end

    // Round chain with in-place schedule expansion over the 16-entry circular buffer.
    // Slot t%16 holds w[t-16] before it is overwritten by w[t].
    for (genvar u = 0; u < UNROLL; u++) begin : g_rnd
        logic [5:0]   w_t;
        logic [3:0]   w_slot;
        logic [31:0]  w_m2, w_m7, w_m15, w_m16, w_wr;
        logic [255:0] w_in, w_out;

        assign w_t    = r_round + 6'(u);
        assign w_slot = w_t[3:0];

        // w[t-2] may have been produced earlier in this same cycle.
        if (u >= 2) begin : g_fwd
            assign w_m2 = g_rnd[u-2].w_wr;
        end else begin : g_buf
            assign w_m2 = r_w[w_slot - 4'd2];
        end

        assign w_m7  = r_w[w_slot - 4'd7];
        assign w_m15 = r_w[w_slot + 4'd1];
        assign w_m16 = r_w[w_slot];
        assign w_wr  = (w_t < 6'd16) ? w_m16 : ssig1(w_m2) + w_m7 + ssig0(w_m15) + w_m16;

        if (u == 0) begin : g_first
            assign w_in = r_work;
        end else begin : g_next
            assign w_in = g_rnd[u-1].w_out;
        end

        sha256_round u_round (
            .i_state (w_in),
            .i_w     (w_wr),
            .i_k     (K[w_t]),
            .o_state (w_out)
        );

        assign w_wr_all[u*32 +: 32] = w_wr;
    end

    assign w_round_out = g_rnd[UNROLL-1].w_out;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle, StLoad: begin
                if (w_accept) begin
                    if (r_idx == 4'd15) w_state_next = StCompress;
                    else if (i_in_last) w_state_next = StPad;
                    else                w_state_next = StLoad;
                end
            end
            StPad:      if (r_idx == 4'd15) w_state_next = StCompress;
            StCompress: if (r_round == LastRound) w_state_next = StFinal;
            StFinal: begin
                if (r_final_blk)     w_state_next = StDone;
                else if (r_msg_done) w_state_next = StPad;
                else                 w_state_next = StLoad;
            end
            StDone:     if (i_digest_ready) w_state_next = StIdle;
            default:    w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= StIdle;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 16; i++) r_w[i] <= '0;
            r_idx       <= '0;
            r_round     <= '0;
            r_h         <= IV;
            r_work      <= '0;
            r_bitcnt    <= '0;
            r_rdy_en    <= 1'b0;
            r_msg_done  <= 1'b0;
            r_pend80    <= 1'b0;
            r_len_ok    <= 1'b0;
            r_final_blk <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            case (r_state)
                StIdle, StLoad: begin
                    if (w_accept) begin
                        r_w[r_idx] <= w_in_word;
                        r_idx      <= r_idx + 4'd1;
                        r_bitcnt   <= r_bitcnt + LEN_W'({i_in_bytes, 3'b000});
                        if (i_in_last) begin
                            r_msg_done <= 1'b1;
                            r_pend80   <= (i_in_bytes >= 3'd4);
                            r_len_ok   <= (i_in_bytes < 3'd4) && (r_idx <= 4'd13);
                        end
                        if (r_idx == 4'd15) begin
                            r_work      <= r_h;
                            r_round     <= '0;
                            r_final_blk <= 1'b0;
                        end
                    end
                end
                StPad: begin
                    r_w[r_idx] <= w_pad_word;
                    r_idx      <= r_idx + 4'd1;
                    if (r_pend80) begin
                        r_pend80 <= 1'b0;
                        r_len_ok <= (r_idx <= 4'd13);
                    end
                    if (r_idx == 4'd15) begin
                        r_work      <= r_h;
                        r_round     <= '0;
                        r_final_blk <= r_len_ok && !r_pend80;
                    end
                end
                StCompress: begin
                    r_work  <= w_round_out;
                    r_round <= r_round + 6'(UNROLL);
                    for (int u = 0; u < UNROLL; u++) begin
                        r_w[r_round[3:0] + 4'(u)] <= w_wr_all[u*32 +: 32];
                    end
                end
                StFinal: begin
                    for (int i = 0; i < 8; i++) begin
                        r_h[i*32 +: 32] <= r_h[i*32 +: 32] + r_work[i*32 +: 32];
                    end
                    r_idx <= '0;
                    // Spill block: the length goes into the fresh block.
                    if (!r_final_blk && r_msg_done) r_len_ok <= 1'b1;
                end
                StDone: begin
                    if (i_digest_ready) begin
                        r_h         <= IV;
                        r_bitcnt    <= '0;
                        r_idx       <= '0;
                        r_msg_done  <= 1'b0;
                        r_pend80    <= 1'b0;
                        r_len_ok    <= 1'b0;
                        r_final_blk <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_256_stream.sv
// Bench for sha_256_stream: three instances (UNROLL 1, 2, 4) exercised one at a time
// with a table of known-answer messages, backpressure sequences and a mid-hash reset.
module tb_sha_256_stream;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] HIV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef struct {
        int           n;
        logic [31:0]  w [16];
        logic [2:0]   lb;
        logic [255:0] exp;
        int           blocks;
    } vec_t;

    vec_t vecs [4];

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  in_data      [3];
    logic         in_valid     [3];
    logic         in_ready     [3];
    logic         in_last      [3];
    logic [2:0]   in_bytes     [3];
    logic [255:0] digest       [3];
    logic         digest_valid [3];
    logic         digest_ready [3];
    logic         busy         [3];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int excl_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // digest_valid and in_ready must never be high together on any instance.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (digest_valid[k] && in_ready[k]) excl_err <= excl_err + 1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sha_256_stream #(
            .UNROLL (1 << g),
            .LEN_W  (64)
        ) u_dut (
            .i_clk          (clk),
            .i_rst_n        (rst_n),
            .i_in_data      (in_data[g]),
            .i_in_valid     (in_valid[g]),
            .o_in_ready     (in_ready[g]),
            .i_in_last      (in_last[g]),
            .i_in_bytes     (in_bytes[g]),
            .o_digest       (digest[g]),
            .o_digest_valid (digest_valid[g]),
            .i_digest_ready (digest_ready[g]),
            .o_busy         (busy[g])
        );
    end

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Plain software SHA-256 compression of one block.
    function automatic logic [255:0] model_block(input logic [255:0] hin, input logic [31:0] m [16]);
        logic [31:0]  w [64];
        logic [31:0]  a, b, c, d, e, f, g, h, t1, t2;
        logic [255:0] st, res;
        for (int t = 0; t < 16; t++) w[t] = m[t];
        for (int t = 16; t < 64; t++) begin
            w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
            t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        st = {a, b, c, d, e, f, g, h};
        for (int i = 0; i < 8; i++) res[i*32 +: 32] = hin[i*32 +: 32] + st[i*32 +: 32];
        return res;
    endfunction

    task automatic check(input string nm, input int k, input logic [255:0] act,
                         input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d got=%0h want=%0h", nm, k, act, exp);
        end
    endtask

    // Present one word and wait (bounded) until it is transferred.
    task automatic push_word(input int k, input logic [31:0] d, input logic last,
                             input logic [2:0] nb);
        bit acc = 0;
        int guard = 0;
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        in_last[k]  = last;
        in_bytes[k] = nb;
        while (!acc && guard < 100) begin
            acc = in_ready[k];
            @(posedge clk); #1;
            guard++;
        end
        check("word_accept", k, acc, 1);
    endtask

    task automatic run_vec(input int k, input int vi, input bit gaps, input int hold);
        int u = 1 << k;
        int t_first = 0;
        int guard = 0;
        bit bad_hold = 0;
        logic [255:0] snap;
        for (int i = 0; i < vecs[vi].n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid[k] = 1'b0;
                    @(posedge clk); #1;
                end
            end
            push_word(k, vecs[vi].w[i], (i == vecs[vi].n - 1),
                      (i == vecs[vi].n - 1) ? vecs[vi].lb : 3'd4);
            if (i == 0) begin
                t_first = cyc;
                check("busy_on", k, busy[k], 1);
            end
        end
        in_valid[k] = gaps;
        in_data[k]  = 32'hdead_beef;
        in_last[k]  = 1'b0;
        while (!digest_valid[k] && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("digest_valid", k, digest_valid[k], 1);
        if (!gaps) check("latency", k, cyc - t_first + 1, vecs[vi].blocks * (17 + 64 / u));
        check("digest", k, digest[k], vecs[vi].exp);
        snap = digest[k];
        repeat (hold) begin
            if (digest[k] !== snap || in_ready[k] !== 1'b0 || digest_valid[k] !== 1'b1)
                bad_hold = 1;
            @(posedge clk); #1;
        end
        check("digest_hold", k, bad_hold, 0);
        in_valid[k]     = 1'b0;
        digest_ready[k] = 1'b1;
        @(posedge clk); #1;
        digest_ready[k] = 1'b0;
        check("after_accept", k, {busy[k], digest_valid[k], in_ready[k]}, 3'b001);
    endtask

    // Reset in the middle of compressing "abc", then hash "Dave".
    task automatic reset_mid(input int k);
        push_word(k, 32'h6162_6300, 1'b1, 3'd3);
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst_outputs", k, {in_ready[k], digest_valid[k], busy[k]}, 3'b000);
        check("rst_digest", k, digest[k], 256'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        check("rst_release_rdy", k, in_ready[k], 0);
        @(posedge clk); #1;
        check("rst_after_rdy", k, {in_ready[k], digest_valid[k], busy[k]}, 3'b100);
        run_vec(k, 3, 0, 1);
    endtask

    initial begin
        logic [31:0] blk [16];
        for (int v = 0; v < 4; v++) begin
            for (int j = 0; j < 16; j++) vecs[v].w[j] = '0;
        end
        // "abc", junk in the unused byte
        vecs[0].n = 1; vecs[0].lb = 3'd3; vecs[0].blocks = 1;
        vecs[0].w[0] = 32'h6162_63ff;
        vecs[0].exp = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
        // empty message, junk data masked by in_bytes=0
        vecs[1].n = 1; vecs[1].lb = 3'd0; vecs[1].blocks = 1;
        vecs[1].w[0] = 32'hdead_beef;
        vecs[1].exp = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
        // 56-byte message: marker lands at word 14, length spills to a second block
        vecs[2].n = 14; vecs[2].lb = 3'd4; vecs[2].blocks = 2;
        for (int j = 0; j < 14; j++) begin
            vecs[2].w[j] = {8'(8'h61 + j), 8'(8'h62 + j), 8'(8'h63 + j), 8'(8'h64 + j)};
        end
        vecs[2].exp = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
        // "Dave": full last word, marker goes into the next word
        vecs[3].n = 1; vecs[3].lb = 3'd4; vecs[3].blocks = 1;
        vecs[3].w[0] = 32'h4461_7665;
        for (int j = 0; j < 16; j++) blk[j] = '0;
        blk[0]  = 32'h4461_7665;
        blk[1]  = 32'h8000_0000;
        blk[15] = 32'd32;
        vecs[3].exp = model_block(HIV, blk);

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_data[k] = '0; in_valid[k] = 1'b0; in_last[k] = 1'b0;
            in_bytes[k] = '0; digest_ready[k] = 1'b0;
        end
        #12;
        for (int k = 0; k < 3; k++) begin
            check("reset_ctl", k, {in_ready[k], digest_valid[k], busy[k]}, 3'b000);
            check("reset_digest", k, digest[k], 256'd0);
        end
        rst_n = 1'b1;
        check("release_rdy", 0, in_ready[0], 0);
        @(posedge clk); #1;
        check("ready_after_release", 0, in_ready[0], 1);

        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < 4; v++) run_vec(k, v, 0, 2);
            run_vec(k, 0, 1, 50);
            run_vec(k, 2, 1, 50);
            reset_mid(k);
        end
        check("excl_valid_ready", 0, excl_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
